// File: rtl/floo_link_slice.sv
// rtl/floo_link_slice.sv - elastic spill-register pipeline slice for one FlooNoC link channel
//
// Cascades NumStages full-throughput spill stages. Each stage has a main slot that
// drives its output and a spill slot that absorbs one flit when the output stalls.
// Ready toward upstream is the registered "spill empty" flag, so no combinational
// path runs from ready_i to ready_o. NumStages = 0 gives a plain wire pass-through.
//
// Optional feature macro: FLOO_LINK_SLICE_PERF_EN adds saturating stall/flit counters.
// Without it both counter ports are tied to zero and no counter flops exist.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   valid_i      upstream flit valid
//   ready_o      slice can accept a flit
//   data_i       upstream flit
//   valid_o      downstream flit valid
//   ready_i      downstream accepts
//   data_o       downstream flit (straight from the last main register)
//   stall_cnt_o  cycles with valid_o && !ready_i (zero without the macro)
//   flit_cnt_o   flits delivered downstream (zero without the macro)
module floo_link_slice #(
    parameter int unsigned NumStages = 1,
    parameter type         flit_t    = logic,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  flit_t               data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output flit_t               data_o,
    output logic [CntWidth-1:0] stall_cnt_o,
    output logic [CntWidth-1:0] flit_cnt_o
);

    // Index s is the input of stage s; index NumStages is the slice output.
    logic  stage_valid [NumStages+1];
    logic  stage_ready [NumStages+1];
    flit_t stage_data  [NumStages+1];

    assign stage_valid[0]         = valid_i;
    assign stage_data[0]          = data_i;
    assign stage_ready[NumStages] = ready_i;

    assign ready_o = stage_ready[0];
    assign valid_o = stage_valid[NumStages];
    assign data_o  = stage_data[NumStages];

    for (genvar s = 0; s < NumStages; s++) begin : g_stage
        logic  main_full;
        logic  spill_full;
        flit_t main_data;
        flit_t spill_data;
        logic  in_hs;
        logic  out_hs;
        logic  main_load;
        logic  spill_load;
        flit_t main_next;

        // Spill empty is the only thing that gates acceptance, so ready is a flop output.
        assign in_hs  = stage_valid[s] && !spill_full;
        assign out_hs = main_full && stage_ready[s+1];

        // Main reloads on a fresh accept when it is empty or being drained, or from
        // spill when it drains while spill holds a flit. in_hs implies spill empty,
        // so the two sources never compete.
        assign main_load  = (in_hs && (!main_full || out_hs)) || (out_hs && spill_full);
        assign main_next  = spill_full ? spill_data : stage_data[s];
        assign spill_load = in_hs && main_full && !out_hs;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                main_full  <= 1'b0;
                spill_full <= 1'b0;
            end else begin
                if (out_hs) begin
                    if (spill_full) begin
                        main_full  <= 1'b1;
                        spill_full <= 1'b0;
                    end else begin
                        main_full  <= in_hs;
                    end
                end else if (in_hs) begin
                    if (main_full) begin
                        spill_full <= 1'b1;
                    end else begin
                        main_full  <= 1'b1;
                    end
                end
            end
        end

        // Only the main register that feeds data_o carries a reset value; the rest
        // of the datapath is qualified by the full flags.
        if (s == int'(NumStages) - 1) begin : g_main_rst
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    main_data <= '0;
                end else if (main_load) begin
                    main_data <= main_next;
                end
            end
        end else begin : g_main_nrst
            always_ff @(posedge clk_i) begin
                if (main_load) begin
                    main_data <= main_next;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (spill_load) begin
                spill_data <= stage_data[s];
            end
        end

        assign stage_ready[s]   = !spill_full;
        assign stage_valid[s+1] = main_full;
        assign stage_data[s+1]  = main_data;
    end

`ifdef FLOO_LINK_SLICE_PERF_EN
    logic [CntWidth-1:0] stall_cnt;
    logic [CntWidth-1:0] flit_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flit_cnt  <= '0;
        end else begin
            if (valid_o && !ready_i && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CntWidth'(1);
            end
            if (valid_o && ready_i && (flit_cnt != '1)) begin
                flit_cnt <= flit_cnt + CntWidth'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flit_cnt_o  = flit_cnt;
`else
    assign stall_cnt_o = '0;
    assign flit_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_floo_link_slice.sv
// tb/tb_floo_link_slice.sv - self-checking bench for floo_link_slice (2-stage and pass-through)
module tb_floo_link_slice;

`ifdef FLOO_LINK_SLICE_PERF_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i, ready_i, ready_o, valid_o;
    logic [7:0]  data_i, data_o;
    logic [31:0] stall_cnt_o, flit_cnt_o;
    logic        valid0_i, ready0_i, ready0_o, valid0_o;
    logic [7:0]  data0_i, data0_o;
    logic [31:0] stall0_cnt_o, flit0_cnt_o;

    always #5 clk = ~clk;

    floo_link_slice #(.NumStages(2), .flit_t(logic [7:0]), .CntWidth(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .stall_cnt_o(stall_cnt_o), .flit_cnt_o(flit_cnt_o)
    );

    floo_link_slice #(.NumStages(0), .flit_t(logic [7:0]), .CntWidth(32)) dut0 (
        .clk_i(clk), .rst_i(rst_i),
        .valid_i(valid0_i), .ready_o(ready0_o), .data_i(data0_i),
        .valid_o(valid0_o), .ready_i(ready0_i), .data_o(data0_o),
        .stall_cnt_o(stall0_cnt_o), .flit_cnt_o(flit0_cnt_o)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a FIFO of accepted-but-undelivered flits plus event counts.
    logic [7:0]  sb [$];
    int          n_acc = 0, n_del = 0, step_no = 0;
    logic [31:0] exp_stall = 0, exp_flit = 0;
    logic        in_acc, out_acc, entry_valid, entry_ready, prev_stalled = 1'b0;
    logic [7:0]  prev_data, out_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the 2-stage slice: entered and left at a falling edge.
    task automatic step(input logic vi, input logic ri, input logic [7:0] di);
        if (prev_stalled) begin
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_data", 32'(data_o), 32'(prev_data));
        end
        entry_valid = valid_o;
        entry_ready = ready_o;
        valid_i = vi;
        ready_i = ri;
        data_i  = di;
        #1;
        in_acc  = valid_i && ready_o;
        out_acc = valid_o && ready_i;
        if (in_acc) begin
            sb.push_back(data_i);
            n_acc++;
        end
        if (out_acc) begin
            out_data = data_o;
            if (sb.size() == 0) chk("spurious_flit", 32'd1, 32'd0);
            else chk("order", 32'(data_o), 32'(sb.pop_front()));
            n_del++;
            exp_flit++;
        end
        if (valid_o && !ready_i) exp_stall++;
        chk("capacity", 32'(sb.size() <= 4), 32'd1);
        prev_stalled = valid_o && !ready_i;
        prev_data    = data_o;
        step_no++;
        @(negedge clk);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_stall_cnt"}, stall_cnt_o, Perf ? exp_stall : 32'd0);
        chk({tag, "_flit_cnt"}, flit_cnt_o, Perf ? exp_flit : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first_acc, first_val, first_del, last_del, idx, guard, base, nf;
        logic [7:0] next_d;
        logic [7:0] first_post;
        logic       exp_exp0;
        int         f0, s0;

        rst_i = 1'b1;
        valid_i = 1'b0; ready_i = 1'b0; data_i = 8'h00;
        valid0_i = 1'b0; ready0_i = 1'b0; data0_i = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk_counters("rst");
        rst_i = 1'b0;
        @(negedge clk);

        // Streaming: 0x01..0x64 back-to-back with ready_i held high.
        first_acc = -1; first_val = -1; first_del = -1; last_del = -1;
        idx = 1; guard = 0; base = n_del;
        while (guard < 300 && (idx <= 100 || sb.size() > 0)) begin
            step(idx <= 100, 1'b1, 8'(idx));
            if (entry_valid && first_val < 0) first_val = step_no - 1;
            if (in_acc) begin
                if (first_acc < 0) first_acc = step_no - 1;
                idx++;
            end
            if (out_acc) begin
                if (first_del < 0) first_del = step_no - 1;
                last_del = step_no - 1;
            end
            guard++;
        end
        chk("stream_delivered", 32'(n_del - base), 32'd100);
        chk("stream_latency", 32'(first_val - first_acc), 32'd2);
        chk("stream_back_to_back", 32'(last_del - first_del), 32'd99);
        chk_counters("stream");
        chk("stream_flit_cnt_100", flit_cnt_o, Perf ? 32'd100 : 32'd0);

        // Fill: downstream stalled, upstream keeps offering 0xA0, 0xA1, ...
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'hA0 + 8'(nf));
            if (in_acc) nf++;
        end
        chk("fill_accepted", 32'(nf), 32'd4);
        chk("fill_ready_o", 32'(ready_o), 32'd0);
        chk("fill_valid_o", 32'(valid_o), 32'd1);
        chk("fill_data_o", 32'(data_o), 32'hA0);
        chk_counters("fill");
        step(1'b1, 1'b0, 8'hA4);
        chk_counters("fill_more");

        // Drain after full: 0xA0..0xA3 on consecutive cycles, ready_o back up quickly.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h00);
            if (i < 4) chk("drain_consecutive", 32'(out_acc), 32'd1);
            if (i < 4) chk("drain_data", 32'(out_data), 32'hA0 + 32'(i));
            if (i == 2) chk("drain_ready_back", 32'(entry_ready), 32'd1);
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk_counters("drain");

        // Random backpressure: 1000 flits, 50% valid and ready duty.
        base = n_acc; guard = 0; next_d = 8'($urandom);
        while (n_acc - base < 1000 && guard < 20000) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), next_d);
            if (in_acc) next_d = 8'($urandom);
            guard++;
        end
        chk("rand_sent", 32'(n_acc - base), 32'd1000);
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            step(1'b0, 1'b1, 8'h00);
            guard++;
        end
        chk("rand_drained", 32'(sb.size()), 32'd0);
        chk("rand_totals", 32'(n_del), 32'(n_acc));
        chk_counters("rand");

        // Reset mid-operation with 3 flits buffered.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
        chk("pre_rst_buffered", 32'(sb.size()), 32'd3);
        valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid_o", 32'(valid_o), 32'd0);
        chk("mid_rst_ready_o", 32'(ready_o), 32'd1);
        chk("mid_rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("mid_rst_flit_cnt", flit_cnt_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        exp_stall = 0; exp_flit = 0; prev_stalled = 1'b0;
        @(negedge clk);
        base = n_del; first_post = 8'h00; guard = 0; idx = 0;
        while (guard < 20 && n_del == base) begin
            step(idx == 0, 1'b1, 8'h55);
            if (in_acc) idx = 1;
            if (out_acc) first_post = out_data;
            guard++;
        end
        chk("post_rst_first_flit", 32'(first_post), 32'h55);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
        chk("post_rst_one_flit", 32'(n_del - base), 32'd1);
        chk_counters("post_rst");

        // Pass-through: NumStages = 0 follows its inputs in the same cycle.
        f0 = 0; s0 = 0;
        for (int i = 0; i < 12; i++) begin
            valid0_i = 1'($urandom_range(0, 1));
            ready0_i = (i % 2) == 0;
            data0_i  = 8'($urandom);
            #1;
            chk("pt_ready", 32'(ready0_o), 32'(ready0_i));
            chk("pt_valid", 32'(valid0_o), 32'(valid0_i));
            chk("pt_data", 32'(data0_o), 32'(data0_i));
            exp_exp0 = valid0_i && ready0_i;
            if (exp_exp0) f0++;
            if (valid0_i && !ready0_i) s0++;
            @(negedge clk);
        end
        chk("pt_flit_cnt", flit0_cnt_o, Perf ? 32'(f0) : 32'd0);
        chk("pt_stall_cnt", stall0_cnt_o, Perf ? 32'(s0) : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
